// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receive and transmit blocks.
package uart_pkg;

    localparam int UART_NB_OVS   = 16;
    localparam int UART_HALF_BIT = UART_NB_OVS / 2;
    localparam int UART_NB_DATA  = 8;
    localparam int UART_NB_STOP  = 2;

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        START = 5'b00010,
        DATA  = 5'b00100,
        STOP  = 5'b01000,
        ERR   = 5'b10000
    } rx_state_e;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchroniser for an asynchronous input that idles high.
module rx_sync (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_sync
);

    logic meta_q;
    logic sync_q;

    // Reset both stages to 1 so a quiet line never looks like a start edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= i_async;
            sync_q <= meta_q;
        end
    end

    assign o_sync = sync_q;

endmodule

// File: rtl/receptor.sv
// UART receiver: 16x-oversampled, LSB-first, idle-high serial to parallel bytes.
module receptor
    import uart_pkg::*;
#(
    parameter int NB_DATA = UART_NB_DATA,
    parameter int NB_STOP = UART_NB_STOP,
    parameter int NB_OVS  = UART_NB_OVS
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_valid,
    output logic               o_frame_err,
    output logic               o_busy
);

    localparam int NBW = $clog2(NB_DATA);
    localparam logic [4:0]     CNT_HALF  = 5'(NB_OVS / 2 - 1);
    localparam logic [4:0]     CNT_LAST  = 5'(NB_OVS - 1);
    localparam logic [NBW-1:0] BIT_LAST  = NBW'(NB_DATA - 1);
    localparam logic [NBW-1:0] STOP_LAST = NBW'(NB_STOP - 1);

    rx_state_e          state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [NBW-1:0]     nbit_q, nbit_d;
    logic [NB_DATA-1:0] shift_q, shift_d;
    logic [NB_DATA-1:0] data_q, data_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               rx_s;

    rx_sync u_rx_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (i_rx),
        .o_sync  (rx_s)
    );

    // Frame sequencing: hunt for a start edge, confirm it mid-bit, then sample
    // each following bit at its centre. The last stop sample ends the frame
    // half a bit early so back-to-back frames resync on the next start edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nbit_d  = nbit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (i_tick) begin
                    if (cnt_q == CNT_HALF) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            cnt_d   = '0;
                            nbit_d  = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            DATA: begin
                if (i_tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d           = '0;
                        shift_d[nbit_q] = rx_s;
                        if (nbit_q == BIT_LAST) begin
                            state_d = STOP;
                            nbit_d  = '0;
                        end else begin
                            nbit_d = nbit_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            STOP: begin
                if (i_tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (!rx_s) begin
                            state_d = ERR;
                            err_d   = 1'b1;
                        end else if (nbit_q == STOP_LAST) begin
                            state_d = IDLE;
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            nbit_d = nbit_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            ERR: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered state, counters and output pulses; reset discards any partial word.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            nbit_q  <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nbit_q  <= nbit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = err_q;
    assign o_busy      = (state_q != IDLE);

endmodule
